pwm_capture_16bits: RTL and testbench

Measures an incoming PWM waveform and recovers its period and high time as 16-bit clock-cycle counts, i.e. the carrier period and compare value that produced it. It is the receive side of the PWM compare stage: loopback/verification of generated PWM outputs, and capture of external PWM references, feeding the processing-system register map. The input is asynchronous and synchronized internally. Each full period yields one result, with timeout reporting for static (0 % / 100 %) inputs.

---
 rtl/pwm_capture_16bits.sv | 136 +++++++++++++
 tb/tb_pwm_capture_16bits.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/pwm_capture_16bits.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pwm_capture_16bits                                            |
// | Purpose  : Measures period and high time of an asynchronous PWM input,   |
// |            with timeout reporting for static inputs.                     |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+

module pwm_capture_16bits #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             enable,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             ovf,
  output logic             level,
  output logic             valid
);

  localparam logic [WIDTH-1:0] C_ALL_ONES = '1;
  localparam logic [WIDTH-1:0] C_ZERO     = '0;
  localparam logic [WIDTH-1:0] C_ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    MEASURE   = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_s1;
  logic             r_s2;
  logic             r_s3;
  logic [WIDTH-1:0] r_period_cnt;
  logic [WIDTH-1:0] r_high_cnt;

  logic             w_rise;
  logic             w_timeout;
  logic [WIDTH-1:0] w_high_inc;

  assign w_rise     = r_s2 & ~r_s3;
  assign w_timeout  = (r_period_cnt == C_ALL_ONES) & ~w_rise;
  assign w_high_inc = {{(WIDTH-1){1'b0}}, r_s2};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= pwm_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // The timeout cycle itself closes the count, so the restarted count begins
  // at 1 and timeouts repeat every 2^WIDTH-1 cycles on a static input.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= IDLE;
      r_period_cnt <= C_ZERO;
      r_high_cnt   <= C_ZERO;
      period       <= C_ZERO;
      high_time    <= C_ZERO;
      ovf          <= 1'b0;
      level        <= 1'b0;
      valid        <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (!enable) begin
        r_state      <= IDLE;
        r_period_cnt <= C_ZERO;
        r_high_cnt   <= C_ZERO;
      end else begin
        case (r_state)
          IDLE: begin
            r_state      <= WAIT_RISE;
            r_period_cnt <= C_ONE;
            r_high_cnt   <= C_ZERO;
          end
          WAIT_RISE: begin
            if (w_rise) begin
              r_state      <= MEASURE;
              r_period_cnt <= C_ONE;
              r_high_cnt   <= C_ONE;
            end else if (w_timeout) begin
              period       <= C_ALL_ONES;
              high_time    <= r_s2 ? C_ALL_ONES : C_ZERO;
              ovf          <= 1'b1;
              level        <= r_s2;
              valid        <= 1'b1;
              r_period_cnt <= C_ONE;
              r_high_cnt   <= C_ZERO;
            end else begin
              r_period_cnt <= r_period_cnt + C_ONE;
            end
          end
          MEASURE: begin
            if (w_rise) begin
              period       <= r_period_cnt;
              high_time    <= r_high_cnt;
              ovf          <= 1'b0;
              valid        <= 1'b1;
              r_period_cnt <= C_ONE;
              r_high_cnt   <= C_ONE;
            end else if (w_timeout) begin
              period       <= C_ALL_ONES;
              high_time    <= r_s2 ? C_ALL_ONES : C_ZERO;
              ovf          <= 1'b1;
              level        <= r_s2;
              valid        <= 1'b1;
              r_state      <= WAIT_RISE;
              r_period_cnt <= C_ONE;
              r_high_cnt   <= C_ZERO;
            end else begin
              r_period_cnt <= r_period_cnt + C_ONE;
              r_high_cnt   <= r_high_cnt + w_high_inc;
            end
          end
          default: begin
            r_state      <= IDLE;
            r_period_cnt <= C_ZERO;
            r_high_cnt   <= C_ZERO;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pwm_capture_16bits.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_pwm_capture_16bits                                         |
// | Purpose  : Scoreboard bench for pwm_capture_16bits (WIDTH=10 so that     |
// |            timeouts occur every 1023 cycles).                            |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+

module tb_pwm_capture_16bits;

  localparam int W = 10;
  localparam int N = (1 << W) - 1;

  typedef struct {
    int p;
    int h;
    int o;
    int l;
    int gap;
  } exp_t;

  logic         clk    = 1'b0;
  logic         rstn   = 1'b1;
  logic         enable = 1'b0;
  logic         pwm_in = 1'b0;
  logic [W-1:0] period;
  logic [W-1:0] high_time;
  logic         ovf;
  logic         level;
  logic         valid;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   last_v = 0;
  exp_t q[$];

  pwm_capture_16bits #(.WIDTH(W)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .enable    (enable),
    .pwm_in    (pwm_in),
    .period    (period),
    .high_time (high_time),
    .ovf       (ovf),
    .level     (level),
    .valid     (valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int p, input int h, input int o, input int l, input int gap);
    exp_t e;
    e.p = p; e.h = h; e.o = o; e.l = l; e.gap = gap;
    q.push_back(e);
  endtask

  task automatic seg(input logic v, input int n);
    pwm_in = v;
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every valid pulse consumes one expected result.
  always @(negedge clk) begin
    if (rstn && valid === 1'b1) begin
      if (q.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("period", int'(period), e.p);
        check("high_time", int'(high_time), e.h);
        check("ovf", int'(ovf), e.o);
        check("level", int'(level), e.l);
        if (e.gap > 0) check("timeout_interval", cyc - last_v, e.gap);
      end
      last_v = cyc;
    end
  end

  initial begin
    #2 rstn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_period", int'(period), 0);
    check("rst_high_time", int'(high_time), 0);
    check("rst_ovf", int'(ovf), 0);
    check("rst_level", int'(level), 0);
    check("rst_valid", int'(valid), 0);
    rstn = 1'b1;
    @(negedge clk);
    enable = 1'b1;
    seg(0, 3);

    // 25 % duty, 1000-cycle period; first period discarded
    seg(1, 250); seg(0, 750);
    push(1000, 250, 0, 0, 0); seg(1, 250); seg(0, 750);
    // compare raised 250->600 at count 400 creates an extra rise
    push(1000, 250, 0, 0, 0); seg(1, 250); seg(0, 150);
    push(400, 250, 0, 0, 0);  seg(1, 200); seg(0, 400);
    push(600, 200, 0, 0, 0);  seg(1, 600); seg(0, 400);
    push(1000, 600, 0, 0, 0); seg(1, 600); seg(0, 400);

    // minimum waveform 1 high / 1 low
    push(1000, 600, 0, 0, 0); seg(1, 1); seg(0, 1);
    repeat (5) begin
      push(2, 1, 0, 0, 0); seg(1, 1); seg(0, 1);
    end

    // static low, then static high
    push(N, 0, 1, 0, 0); push(N, 0, 1, 0, N);
    seg(0, 2 * N + 20);
    push(N, N, 1, 1, 0); push(N, N, 1, 1, N);
    seg(1, 2 * N + 20);

    // enable dropped mid-period
    seg(0, 10);
    seg(1, 100); seg(0, 100);
    push(200, 100, 0, 1, 0); seg(1, 100); seg(0, 50);
    enable = 1'b0;
    seg(0, 20); seg(1, 30); seg(0, 30);
    check("hold_period", int'(period), 200);
    check("hold_high_time", int'(high_time), 100);
    check("hold_ovf", int'(ovf), 0);
    check("hold_level", int'(level), 1);
    enable = 1'b1;
    seg(0, 5);
    seg(1, 300); seg(0, 200);
    push(500, 300, 0, 1, 0); seg(1, 300); seg(0, 200);
    push(500, 300, 0, 1, 0); seg(1, 300); seg(0, 100);

    // asynchronous reset mid-period
    rstn = 1'b0;
    #1;
    check("arst_period", int'(period), 0);
    check("arst_high_time", int'(high_time), 0);
    check("arst_ovf", int'(ovf), 0);
    check("arst_level", int'(level), 0);
    check("arst_valid", int'(valid), 0);
    @(negedge clk);
    rstn = 1'b1;
    seg(0, 5);
    seg(1, 40); seg(0, 60);
    push(100, 40, 0, 0, 0); seg(1, 40); seg(0, 60);
    push(100, 40, 0, 0, 0); seg(1, 5); seg(0, 10);

    check("pending_results", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
